conv_matrix_loader: RTL and testbench

- Front-end producer for the 4x4-input / 3x3-filter convolution engine.
- Accepts a byte stream over a valid/ready handshake and assembles it into the 16 input-matrix and 9 filter-matrix registers, which drive the engine's parallel operand ports.
- Sequences the engine's reset/run window and flags when the engine's 2x2 result is stable.
- Sits between the host byte interface and the convolution engine; it owns the engine's reset line.

---
 rtl/conv_matrix_loader.sv | 159 +++++++++++++++
 tb/tb_conv_matrix_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_matrix_loader.sv
// Byte-stream loader for the 4x4 input / 3x3 filter convolution engine.
// Fills 25 operand registers, then sequences the engine reset/run window.
module conv_matrix_loader #(
   parameter int unsigned RUN_CYCLES = 66,
   parameter int unsigned FRAME_LEN  = 25
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic       load_abort,
   output logic [7:0] i00,
   output logic [7:0] i01,
   output logic [7:0] i02,
   output logic [7:0] i03,
   output logic [7:0] i10,
   output logic [7:0] i11,
   output logic [7:0] i12,
   output logic [7:0] i13,
   output logic [7:0] i20,
   output logic [7:0] i21,
   output logic [7:0] i22,
   output logic [7:0] i23,
   output logic [7:0] i30,
   output logic [7:0] i31,
   output logic [7:0] i32,
   output logic [7:0] i33,
   output logic [7:0] f00,
   output logic [7:0] f01,
   output logic [7:0] f02,
   output logic [7:0] f10,
   output logic [7:0] f11,
   output logic [7:0] f12,
   output logic [7:0] f20,
   output logic [7:0] f21,
   output logic [7:0] f22,
   output logic       conv_rst,
   output logic       busy,
   output logic       done,
   output logic [4:0] byte_idx
);

   localparam logic [1:0] StLoad = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [4:0] LastIdx = 5'(FRAME_LEN - 1);
   localparam logic [7:0] RunLast = 8'(RUN_CYCLES - 1);

   logic [1:0] state_q, state_d;
   logic [4:0] idx_q, idx_d;
   logic [7:0] cnt_q, cnt_d;
   logic       conv_rst_q, busy_q, done_q;
   logic [7:0] mat_q [FRAME_LEN];
   logic       wr_en;
   logic [4:0] wr_idx;
   logic       xfer;

   assign s_ready = (state_q == StLoad) || (state_q == StDone);
   assign xfer    = s_valid & s_ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_idx  = idx_q;
      case (state_q)
         StLoad: begin
            // Abort takes priority: a simultaneous byte is dropped.
            if (load_abort) begin
               idx_d = 5'd0;
            end else if (xfer) begin
               wr_en = 1'b1;
               if (idx_q == LastIdx) begin
                  idx_d   = 5'd0;
                  cnt_d   = 8'd0;
                  state_d = StRun;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         StRun: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == RunLast) begin
               state_d = StDone;
            end
         end
         StDone: begin
            // First byte of the next frame restarts loading directly.
            if (xfer) begin
               wr_en   = 1'b1;
               wr_idx  = 5'd0;
               idx_d   = 5'd1;
               state_d = StLoad;
            end
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q    <= StLoad;
         idx_q      <= 5'd0;
         cnt_q      <= 8'd0;
         conv_rst_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int k = 0; k < int'(FRAME_LEN); k++) begin
            mat_q[k] <= 8'd0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         conv_rst_q <= (state_d == StLoad);
         busy_q     <= (state_d == StRun);
         done_q     <= (state_d == StDone);
         if (wr_en) begin
            mat_q[wr_idx] <= s_data;
         end
      end
   end

   assign conv_rst = conv_rst_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign byte_idx = idx_q;

   assign i00 = mat_q[0];
   assign i01 = mat_q[1];
   assign i02 = mat_q[2];
   assign i03 = mat_q[3];
   assign i10 = mat_q[4];
   assign i11 = mat_q[5];
   assign i12 = mat_q[6];
   assign i13 = mat_q[7];
   assign i20 = mat_q[8];
   assign i21 = mat_q[9];
   assign i22 = mat_q[10];
   assign i23 = mat_q[11];
   assign i30 = mat_q[12];
   assign i31 = mat_q[13];
   assign i32 = mat_q[14];
   assign i33 = mat_q[15];
   assign f00 = mat_q[16];
   assign f01 = mat_q[17];
   assign f02 = mat_q[18];
   assign f10 = mat_q[19];
   assign f11 = mat_q[20];
   assign f12 = mat_q[21];
   assign f20 = mat_q[22];
   assign f21 = mat_q[23];
   assign f22 = mat_q[24];

endmodule

// File: tb/tb_conv_matrix_loader.sv
// Bench for conv_matrix_loader: frame-level model checked every cycle,
// plus directed literal checks of register contents and engine results.
module tb_conv_matrix_loader;

   localparam int RunCycles = 66;
   localparam int MLoad = 0;
   localparam int MRun  = 1;
   localparam int MDone = 2;

   logic       clk_in = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       load_abort = 1'b0;
   logic       s_ready, conv_rst, busy, done;
   logic [4:0] byte_idx;
   logic [7:0] i00, i01, i02, i03, i10, i11, i12, i13;
   logic [7:0] i20, i21, i22, i23, i30, i31, i32, i33;
   logic [7:0] f00, f01, f02, f10, f11, f12, f20, f21, f22;
   logic [199:0] dut_mat;

   int n_checks = 0;
   int n_errors = 0;

   conv_matrix_loader #(.RUN_CYCLES(RunCycles)) dut (
      .clk_in(clk_in), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .load_abort(load_abort),
      .i00(i00), .i01(i01), .i02(i02), .i03(i03), .i10(i10), .i11(i11), .i12(i12), .i13(i13),
      .i20(i20), .i21(i21), .i22(i22), .i23(i23), .i30(i30), .i31(i31), .i32(i32), .i33(i33),
      .f00(f00), .f01(f01), .f02(f02), .f10(f10), .f11(f11), .f12(f12),
      .f20(f20), .f21(f21), .f22(f22),
      .conv_rst(conv_rst), .busy(busy), .done(done), .byte_idx(byte_idx)
   );

   always #5 clk_in = ~clk_in;

   assign dut_mat = {i00, i01, i02, i03, i10, i11, i12, i13, i20, i21, i22, i23,
                     i30, i31, i32, i33, f00, f01, f02, f10, f11, f12, f20, f21, f22};

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_mat(input string name, input logic [199:0] act, input logic [199:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // 2x2 valid convolution the engine would produce from the loaded operands.
   function automatic int conv_out(input logic [199:0] m, input int r, input int c);
      int s = 0;
      for (int a = 0; a < 3; a++) begin
         for (int b = 0; b < 3; b++) begin
            s += int'(m[199 - 8 * ((r + a) * 4 + c + b) -: 8]) *
                 int'(m[199 - 8 * (16 + a * 3 + b) -: 8]);
         end
      end
      return s;
   endfunction

   // Frame-level model: mode, next slot, cycles left in the run window.
   int         m_mode = MLoad;
   int         m_idx = 0;
   int         m_left = 0;
   bit         m_valid = 1'b0;
   logic [7:0] m_mat [25];

   always @(posedge clk_in) begin
      if (rst) begin
         m_valid = 1'b1;
         m_mode  = MLoad;
         m_idx   = 0;
         m_left  = 0;
         for (int k = 0; k < 25; k++) m_mat[k] = 8'h00;
      end else if (m_mode == MLoad) begin
         if (load_abort) begin
            m_idx = 0;
         end else if (s_valid) begin
            m_mat[m_idx] = s_data;
            if (m_idx == 24) begin
               m_idx  = 0;
               m_mode = MRun;
               m_left = RunCycles;
            end else begin
               m_idx++;
            end
         end
      end else if (m_mode == MRun) begin
         m_left--;
         if (m_left == 0) m_mode = MDone;
      end else if (s_valid) begin
         m_mat[0] = s_data;
         m_idx    = 1;
         m_mode   = MLoad;
      end
   end

   always @(negedge clk_in) begin
      logic [199:0] exp_mat;
      if (m_valid) begin
         for (int k = 0; k < 25; k++) exp_mat[199 - 8 * k -: 8] = m_mat[k];
         chk("byte_idx", 32'(byte_idx), m_idx);
         chk("flags", 32'({s_ready, conv_rst, busy, done}),
             32'({m_mode != MRun, m_mode == MLoad, m_mode == MRun, m_mode == MDone}));
         chk_mat("matrix", dut_mat, exp_mat);
         chk("busy_done_excl", 32'(busy & done), 0);
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d);
      s_valid = 1'b1;
      s_data  = d;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic send_gappy(input logic [7:0] d);
      bit v;
      for (int n = 0; n < 1000; n++) begin
         v       = ($urandom_range(0, 99) < 40);
         s_valid = v;
         s_data  = v ? d : 8'hEE;
         tick();
         if (v) break;
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 500) begin
         tick();
         n++;
      end
   endtask

   function automatic logic [7:0] frame_byte(input int k);
      return (k < 16) ? 8'(k + 1) : 8'd1;
   endfunction

   task automatic chk_results(input string tag);
      chk({tag, "_o00"}, conv_out(dut_mat, 0, 0), 54);
      chk({tag, "_o01"}, conv_out(dut_mat, 0, 1), 63);
      chk({tag, "_o10"}, conv_out(dut_mat, 1, 0), 90);
      chk({tag, "_o11"}, conv_out(dut_mat, 1, 1), 99);
   endtask

   initial begin
      int n;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_idx", 32'(byte_idx), 0);
      chk("rst_flags", 32'({s_ready, conv_rst, busy, done}), 32'(4'b1100));

      // Back-to-back frame, then 0xAA held valid through the whole run window.
      for (int k = 0; k < 25; k++) begin
         s_valid = 1'b1;
         s_data  = frame_byte(k);
         tick();
      end
      chk("run_entry_flags", 32'({s_ready, conv_rst, busy, done}), 32'(4'b0010));
      s_data = 8'hAA;
      wait_done(n);
      s_valid = 1'b0;
      chk("done_latency", n, RunCycles);
      chk("i00", 32'(i00), 1);
      chk("i33", 32'(i33), 16);
      chk("f11", 32'(f11), 1);
      chk("f22", 32'(f22), 1);
      chk("idx_after_run", 32'(byte_idx), 0);
      chk_results("back2back");

      // New frame byte in DONE.
      send_byte(8'h05);
      chk("done_i00", 32'(i00), 5);
      chk("done_idx", 32'(byte_idx), 1);
      chk("done_exit_flags", 32'({conv_rst, done}), 32'(2'b10));

      // Abort, ten bytes, then abort colliding with a valid 0x77.
      load_abort = 1'b1;
      tick();
      load_abort = 1'b0;
      for (int k = 0; k < 10; k++) send_byte(8'h30 + 8'(k));
      chk("idx_ten", 32'(byte_idx), 10);
      load_abort = 1'b1;
      send_byte(8'h77);
      load_abort = 1'b0;
      chk("abort_idx", 32'(byte_idx), 0);
      chk("abort_i22", 32'(i22), 11);
      send_byte(8'h42);
      chk("after_abort_i00", 32'(i00), 8'h42);
      chk("after_abort_idx", 32'(byte_idx), 1);

      // Same frame with sparse valid.
      load_abort = 1'b1;
      tick();
      load_abort = 1'b0;
      for (int k = 0; k < 25; k++) send_gappy(frame_byte(k));
      wait_done(n);
      chk("gappy_done_latency", n, RunCycles);
      chk_results("gappy");

      // Reset during the run window.
      for (int k = 0; k < 25; k++) send_byte(8'(k + 100));
      for (int k = 0; k < 29; k++) tick();
      chk("mid_run_busy", 32'(busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_run_flags", 32'({s_ready, conv_rst, busy, done}), 32'(4'b1100));
      chk_mat("rst_run_matrix", dut_mat, 200'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
